// File: rtl/pd_pkg.sv
// Shared widths, saturation limits, FSM encoding and saturating-sum helper for the PD sequencer.
package pd_pkg;

    localparam int ERR_W  = 16;
    localparam int PT_W   = 10;
    localparam int DT_W   = 12;
    localparam int CTRL_W = 12;
    localparam int SUM_W  = CTRL_W + 1;

    localparam logic signed [CTRL_W-1:0] CTRL_MAX = 12'h7FF;
    localparam logic signed [CTRL_W-1:0] CTRL_MIN = 12'h800;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        SUM   = 2'd3
    } state_t;

    // Sum fits in 13 bits, so overflow is exactly "top two bits disagree".
    function automatic logic signed [CTRL_W-1:0] sat_ctrl(
        input logic signed [PT_W-1:0] p,
        input logic signed [DT_W-1:0] d
    );
        logic signed [SUM_W-1:0] s;
        s = {{(SUM_W-PT_W){p[PT_W-1]}}, p} + {{(SUM_W-DT_W){d[DT_W-1]}}, d};
        if (s[SUM_W-1] != s[SUM_W-2])
            return s[SUM_W-1] ? CTRL_MIN : CTRL_MAX;
        return s[CTRL_W-1:0];
    endfunction

endpackage

// File: rtl/pd_seq.sv
// PD sample sequencer: buffers inertial samples, strobes the PD engine, saturates pterm+dterm.
// Latency: vld -> pd_vld +1 cycle, -> ctrl_rdy +2+PD_LAT cycles (from IDLE).
// No backpressure: a sample landing on a pending one overwrites it and sets overrun. PD_SEQ_RAMP_EN slews the setpoint.
module pd_seq
    import pd_pkg::*;
#(
    parameter int PD_LAT  = 3,
    parameter int TMO_CYC = 1_000_000,
    parameter int SLEW    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     vld,
    input  logic signed [ERR_W-1:0]  actual,
    input  logic signed [ERR_W-1:0]  desired,
    input  logic signed [PT_W-1:0]   pterm,
    input  logic signed [DT_W-1:0]   dterm,
    output logic                     pd_vld,
    output logic signed [ERR_W-1:0]  pd_actual,
    output logic signed [ERR_W-1:0]  pd_desired,
    output logic signed [CTRL_W-1:0] ctrl_out,
    output logic                     ctrl_rdy,
    output logic                     overrun,
    output logic                     stall
);

    localparam int LAT_W = (PD_LAT > 1) ? $clog2(PD_LAT) : 1;
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(PD_LAT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    state_t                   state;
    logic                     pending;
    logic signed [ERR_W-1:0]  buf_actual;
    logic signed [ERR_W-1:0]  buf_desired;
    logic [LAT_W-1:0]         lat_cnt;
    logic [TMO_W-1:0]         tmo_cnt;
    logic                     en_q;

    // A sample arriving in IDLE is issued straight away, bypassing the buffer.
    logic signed [ERR_W-1:0]  src_actual;
    logic signed [ERR_W-1:0]  src_desired;
    logic signed [ERR_W-1:0]  next_desired;

    assign src_actual  = vld ? actual  : buf_actual;
    assign src_desired = vld ? desired : buf_desired;

`ifdef PD_SEQ_RAMP_EN
    localparam logic signed [ERR_W:0] SLEW_S = (ERR_W+1)'(SLEW);
    logic signed [ERR_W:0] step_diff;

    assign step_diff = {src_desired[ERR_W-1], src_desired} - {pd_desired[ERR_W-1], pd_desired};

    always_comb begin
        next_desired = src_desired;
        if (step_diff > SLEW_S)
            next_desired = pd_desired + SLEW_S[ERR_W-1:0];
        else if (step_diff < -SLEW_S)
            next_desired = pd_desired - SLEW_S[ERR_W-1:0];
    end
`else
    logic unused_slew;
    assign unused_slew  = (SLEW != 0);
    assign next_desired = src_desired;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pending     <= 1'b0;
            buf_actual  <= '0;
            buf_desired <= '0;
            lat_cnt     <= '0;
            tmo_cnt     <= '0;
            en_q        <= 1'b0;
            pd_vld      <= 1'b0;
            pd_actual   <= '0;
            pd_desired  <= '0;
            ctrl_out    <= '0;
            ctrl_rdy    <= 1'b0;
            overrun     <= 1'b0;
            stall       <= 1'b0;
        end else begin
            pd_vld   <= 1'b0;
            ctrl_rdy <= 1'b0;
            en_q     <= en;

            if (en && !en_q) begin
                overrun <= 1'b0;
                stall   <= 1'b0;
            end

            if (vld) begin
                buf_actual  <= actual;
                buf_desired <= desired;
                pending     <= 1'b1;
                if (pending)
                    overrun <= 1'b1;
            end

            if (!en || vld)
                tmo_cnt <= '0;
            else if (tmo_cnt == TMO_LAST)
                stall <= 1'b1;
            else
                tmo_cnt <= tmo_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (en && (pending || vld)) begin
                        state      <= ISSUE;
                        pd_vld     <= 1'b1;
                        pd_actual  <= src_actual;
                        pd_desired <= next_desired;
                        pending    <= 1'b0;
                    end
                end
                ISSUE: begin
                    state   <= WAIT;
                    lat_cnt <= '0;
                end
                WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        state    <= SUM;
                        ctrl_out <= sat_ctrl(pterm, dterm);
                        ctrl_rdy <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                SUM:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pd_seq.sv
// Randomized and directed bench for pd_seq against a transaction-level reference model.
module tb_pd_seq;

    localparam int PD_LAT  = 3;
    localparam int TMO_CYC = 40;
    localparam int SLEW    = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic               vld = 1'b0;
    logic signed [15:0] actual = '0;
    logic signed [15:0] desired = '0;
    logic signed [9:0]  pterm = '0;
    logic signed [11:0] dterm = '0;
    logic               pd_vld;
    logic signed [15:0] pd_actual;
    logic signed [15:0] pd_desired;
    logic signed [11:0] ctrl_out;
    logic               ctrl_rdy;
    logic               overrun;
    logic               stall;

    pd_seq #(.PD_LAT(PD_LAT), .TMO_CYC(TMO_CYC), .SLEW(SLEW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .vld(vld),
        .actual(actual), .desired(desired), .pterm(pterm), .dterm(dterm),
        .pd_vld(pd_vld), .pd_actual(pd_actual), .pd_desired(pd_desired),
        .ctrl_out(ctrl_out), .ctrl_rdy(ctrl_rdy), .overrun(overrun), .stall(stall)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one pending slot, a busy countdown per issued sample, an idle-run length.
    int m_busy, m_run, m_pa, m_pd;
    bit m_pend, m_en_prev;
    bit e_pd_vld, e_rdy, e_ovr, e_stall;
    int e_act, e_des, e_ctrl;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    function automatic int sat(input int s);
        if (s > 2047) return 2047;
        if (s < -2048) return -2048;
        return s;
    endfunction

    function automatic int ramp(input int prev, input int tgt);
`ifdef PD_SEQ_RAMP_EN
        if (tgt - prev > SLEW) return prev + SLEW;
        if (tgt - prev < -SLEW) return prev - SLEW;
`endif
        return tgt;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_run = 0; m_pa = 0; m_pd = 0; m_pend = 0; m_en_prev = 0;
        e_pd_vld = 0; e_rdy = 0; e_ovr = 0; e_stall = 0; e_act = 0; e_des = 0; e_ctrl = 0;
    endtask

    task automatic model_edge();
        e_pd_vld = 0;
        e_rdy    = 0;
        if (en && !m_en_prev) begin
            e_ovr   = 0;
            e_stall = 0;
        end
        if (vld) begin
            if (m_pend) e_ovr = 1;
            m_pend = 1;
            m_pa   = int'(actual);
            m_pd   = int'(desired);
        end
        if (en && !vld) begin
            if (m_run < TMO_CYC) m_run++;
        end else begin
            m_run = 0;
        end
        if (m_run >= TMO_CYC) e_stall = 1;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 1) begin
                e_rdy  = 1;
                e_ctrl = sat(int'(pterm) + int'(dterm));
            end
        end else if (en && m_pend) begin
            m_busy   = PD_LAT + 2;
            e_pd_vld = 1;
            e_act    = m_pa;
            e_des    = ramp(e_des, m_pd);
            m_pend   = 0;
        end
        m_en_prev = en;
    endtask

    task automatic compare_all();
        check("pd_vld", pd_vld, e_pd_vld);
        check("pd_actual", pd_actual, e_act);
        check("pd_desired", pd_desired, e_des);
        check("ctrl_rdy", ctrl_rdy, e_rdy);
        check("ctrl_out", ctrl_out, e_ctrl);
        check("overrun", overrun, e_ovr);
        check("stall", stall, e_stall);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pd_vld"}, pd_vld, 0);
        check({tag, "_pd_actual"}, pd_actual, 0);
        check({tag, "_pd_desired"}, pd_desired, 0);
        check({tag, "_ctrl_out"}, ctrl_out, 0);
        check({tag, "_ctrl_rdy"}, ctrl_rdy, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_stall"}, stall, 0);
    endtask

    task automatic tick(input bit e, input bit v, input int a, input int d, input int pt, input int dt);
        en = e; vld = v;
        actual = 16'(a); desired = 16'(d); pterm = 10'(pt); dterm = 12'(dt);
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // lat counts cycles from the vld cycle to the ctrl_rdy cycle; -1 if it never came.
    task automatic run_sample(input int a, input int d, input int pt, input int dt,
                              output bit pv, output int lat, output int outv);
        lat = -1; outv = 0;
        tick(1, 1, a, d, pt, dt);
        pv = pd_vld;
        for (int k = 1; k <= PD_LAT + 6; k++) begin
            tick(1, 0, a, d, pt, dt);
            if (ctrl_rdy && lat < 0) begin
                lat  = k + 1;
                outv = int'(ctrl_out);
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pv;
        int lat, outv, rdy_cnt, pv_cnt, i0, i1;
        int issued[$];
        bit en_r;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // single sample, known engine values
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        run_sample(100, 0, 62, -7, pv, lat, outv);
        check("single_pd_vld_next", pv, 1);
        check("single_latency", lat, PD_LAT + 2);
        check("single_ctrl_out", outv, 55);

        // saturation at both rails
        run_sample(5, -5, 511, 2047, pv, lat, outv);
        check("sat_pos", outv, 2047);
        run_sample(-5, 5, -512, -2048, pv, lat, outv);
        check("sat_neg", outv, -2048);
        check("sat_neg_latency", lat, PD_LAT + 2);

        // three samples while busy: middle one lost
        rdy_cnt = 0;
        issued.delete();
        for (int k = 0; k < 18; k++) begin
            if (k == 0)      tick(1, 1, 11, 1, 3, 4);
            else if (k == 2) tick(1, 1, 22, 2, 3, 4);
            else if (k == 4) tick(1, 1, 33, 3, 3, 4);
            else             tick(1, 0, 0, 0, 3, 4);
            if (ctrl_rdy) rdy_cnt++;
            if (pd_vld) issued.push_back(int'(pd_actual));
        end
        i0 = (issued.size() > 0) ? issued[0] : -1;
        i1 = (issued.size() > 1) ? issued[1] : -1;
        check("ovr_flag", overrun, 1);
        check("ovr_rdy_count", rdy_cnt, 2);
        check("ovr_issue_count", issued.size(), 2);
        check("ovr_first_issued", i0, 11);
        check("ovr_second_issued", i1, 33);

        // disabled: sample retained, issued once enabled (rising edge also clears overrun)
        pv_cnt = 0;
        tick(0, 1, 777, 7, 0, 0);
        if (pd_vld) pv_cnt++;
        for (int k = 0; k < 4; k++) begin
            tick(0, 0, 0, 0, 0, 0);
            if (pd_vld) pv_cnt++;
        end
        check("dis_no_issue", pv_cnt, 0);
        tick(1, 0, 0, 0, 0, 0);
        check("dis_issue_on_en", pd_vld, 1);
        check("dis_retained", pd_actual, 777);
        check("dis_ovr_cleared", overrun, 0);
        for (int k = 0; k < PD_LAT + 3; k++) tick(1, 0, 0, 0, 0, 0);

        // stall timeout and clear on en rising edge
        tick(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < TMO_CYC - 1; k++) tick(1, 0, 0, 0, 0, 0);
        check("stall_before", stall, 0);
        tick(1, 0, 0, 0, 0, 0);
        check("stall_set", stall, 1);
        for (int k = 0; k < 5; k++) tick(1, 0, 0, 0, 0, 0);
        check("stall_sticky", stall, 1);
        tick(0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        check("stall_cleared", stall, 0);

        // reset in WAIT
        tick(1, 1, 300, 30, 50, 50);
        tick(1, 0, 300, 30, 50, 50);
        #3 rst_n = 1'b0;
        #1;
        check_zero("rst_wait");
        model_reset();
        rdy_cnt = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ctrl_rdy) rdy_cnt++;
        end
        check("rst_no_rdy", rdy_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        run_sample(100, 0, 62, -7, pv, lat, outv);
        check("rst_after_latency", lat, PD_LAT + 2);
        check("rst_after_out", outv, 55);

        // setpoint step 0 -> 100 over four samples
        for (int k = 1; k <= 4; k++) begin
            run_sample(1, 100, 0, 0, pv, lat, outv);
`ifdef PD_SEQ_RAMP_EN
            check("ramp_step", pd_desired, 16 * k);
`else
            check("direct_step", pd_desired, 100);
`endif
        end

        // random traffic
        en_r = 1'b1;
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 59) == 0) en_r = ~en_r;
            tick(en_r, $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 1023)) - 512,
                 int'($urandom_range(0, 4095)) - 2048);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
